// File: rtl/sram_port_arbiter.sv
// Two-port arbiter (instruction read-only, data read/write) in front of one single-port SRAM.
// Build option ROUND_ROBIN_EN swaps fixed D priority with starvation guard for alternation.
module sram_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic              I_GNT,
    output logic              I_RVALID,
    output logic [31:0]       I_RDATA,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [3:0]        D_BE,
    input  logic [31:0]       D_WDATA,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic [31:0]       D_RDATA,
    output logic              M_CSN,
    output logic              M_WEN,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [3:0]        M_BE,
    output logic [31:0]       M_DI,
    input  logic [31:0]       M_DOUT
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e rd_owner_q;
    owner_e rd_owner_d;
    logic   i_gnt_s;
    logic   d_gnt_s;
    logic   i_wins_s;

`ifdef ROUND_ROBIN_EN
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    port_e rr_last_q;
    port_e rr_last_d;

    // Remember which port was served last so a conflict goes to the other one.
    always_comb begin
        rr_last_d = rr_last_q;
        if (i_gnt_s) begin
            rr_last_d = PORT_I;
        end else if (d_gnt_s) begin
            rr_last_d = PORT_D;
        end else begin
            rr_last_d = rr_last_q;
        end
    end

    // Round-robin history register.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            rr_last_q <= PORT_I;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

    assign i_wins_s = (rr_last_q == PORT_D);
`else
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    // Count consecutive denied I cycles; any grant or idle I cycle restarts the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (I_REQ && !i_gnt_s) begin
            if (starve_cnt_q == STARVE_MAX) begin
                starve_cnt_d = STARVE_MAX;
            end else begin
                starve_cnt_d = starve_cnt_q + CNT_ONE;
            end
        end else begin
            starve_cnt_d = '0;
        end
    end

    // Starvation counter register.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign i_wins_s = (starve_cnt_q == STARVE_MAX);
`endif

    // Grant decision: a lone requester always wins; conflicts follow the priority state.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (!RSTn) begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (I_REQ && D_REQ) begin
            i_gnt_s = i_wins_s;
            d_gnt_s = !i_wins_s;
        end else begin
            i_gnt_s = I_REQ;
            d_gnt_s = D_REQ;
        end
    end

    assign I_GNT = i_gnt_s;
    assign D_GNT = d_gnt_s;

    // SRAM pin mux: idle values unless a port holds the grant this cycle.
    always_comb begin
        M_CSN  = 1'b1;
        M_WEN  = 1'b1;
        M_ADDR = '0;
        M_BE   = 4'h0;
        M_DI   = 32'h0000_0000;
        case ({i_gnt_s, d_gnt_s})
            2'b10: begin
                M_CSN  = 1'b0;
                M_WEN  = 1'b1;
                M_ADDR = I_ADDR;
                M_BE   = 4'hF;
            end
            2'b01: begin
                M_CSN  = 1'b0;
                M_WEN  = !D_WE;
                M_ADDR = D_ADDR;
                M_BE   = D_BE;
                M_DI   = D_WDATA;
            end
            default: begin
                M_CSN  = 1'b1;
                M_WEN  = 1'b1;
                M_ADDR = '0;
                M_BE   = 4'h0;
                M_DI   = 32'h0000_0000;
            end
        endcase
    end

    // Tag the port whose read is issued now; writes produce no response.
    always_comb begin
        rd_owner_d = OWN_NONE;
        if (i_gnt_s) begin
            rd_owner_d = OWN_I;
        end else if (d_gnt_s && !D_WE) begin
            rd_owner_d = OWN_D;
        end else begin
            rd_owner_d = OWN_NONE;
        end
    end

    // Read-response owner register.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    // Route SRAM output; a reset during the response cycle suppresses it.
    always_comb begin
        I_RVALID = 1'b0;
        D_RVALID = 1'b0;
        I_RDATA  = 32'h0000_0000;
        D_RDATA  = 32'h0000_0000;
        case (rd_owner_q)
            OWN_I: begin
                I_RVALID = RSTn;
                I_RDATA  = RSTn ? M_DOUT : 32'h0000_0000;
            end
            OWN_D: begin
                D_RVALID = RSTn;
                D_RDATA  = RSTn ? M_DOUT : 32'h0000_0000;
            end
            default: begin
                I_RVALID = 1'b0;
                D_RVALID = 1'b0;
                I_RDATA  = 32'h0000_0000;
                D_RDATA  = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: stimulus pushes expected read responses into a
// queue, a negedge monitor pops and compares them against I/D RVALID/RDATA.
module tb_sram_port_arbiter;

    logic        CLK;
    logic        RSTn;
    logic        I_REQ;
    logic [11:0] I_ADDR;
    logic        I_GNT;
    logic        I_RVALID;
    logic [31:0] I_RDATA;
    logic        D_REQ;
    logic        D_WE;
    logic [11:0] D_ADDR;
    logic [3:0]  D_BE;
    logic [31:0] D_WDATA;
    logic        D_GNT;
    logic        D_RVALID;
    logic [31:0] D_RDATA;
    logic        M_CSN;
    logic        M_WEN;
    logic [11:0] M_ADDR;
    logic [3:0]  M_BE;
    logic [31:0] M_DI;
    logic [31:0] M_DOUT;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rsp_q[$];
    rsp_t        mon_e;
    int          total;
    int          bad;
    logic [31:0] mem [0:4095];

    sram_port_arbiter #(.ADDR_W(12), .STARVE_LIMIT(4), .CNT_W(3)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_BE(D_BE), .D_WDATA(D_WDATA),
        .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
        .M_CSN(M_CSN), .M_WEN(M_WEN), .M_ADDR(M_ADDR), .M_BE(M_BE), .M_DI(M_DI),
        .M_DOUT(M_DOUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // SRAM model: byte-masked write, read data registered at the access edge.
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = i;
        mem[16] = 32'h0;
        M_DOUT = 32'h0;
    end

    always @(posedge CLK) begin
        if (!M_CSN) begin
            if (!M_WEN) begin
                for (int b = 0; b < 4; b++)
                    if (M_BE[b]) mem[M_ADDR][8*b +: 8] <= M_DI[8*b +: 8];
            end else begin
                M_DOUT <= mem[M_ADDR];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic [31:0] data);
        rsp_t e;
        e.is_d = is_d;
        e.data = data;
        rsp_q.push_back(e);
    endtask

    task automatic cyc(input logic ei, input logic ed, input string nm);
        @(negedge CLK);
        chk({nm, "_i_gnt"}, {31'h0, I_GNT}, {31'h0, ei});
        chk({nm, "_d_gnt"}, {31'h0, D_GNT}, {31'h0, ed});
        chk({nm, "_csn"}, {31'h0, M_CSN}, {31'h0, ~(ei | ed)});
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    // Response monitor: every RVALID must match the oldest expected response.
    always @(negedge CLK) begin
        if (I_RVALID && D_RVALID) begin
            chk("both_rvalid", 32'h1, 32'h0);
        end else if (I_RVALID || D_RVALID) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rvalid", {31'h0, D_RVALID}, 32'h2);
            end else begin
                mon_e = rsp_q.pop_front();
                chk("rsp_port_is_d", {31'h0, D_RVALID}, {31'h0, mon_e.is_d});
                chk("rsp_data", D_RVALID ? D_RDATA : I_RDATA, mon_e.data);
            end
        end
        if (!I_RVALID) chk("i_rdata_idle", I_RDATA, 32'h0);
        if (!D_RVALID) chk("d_rdata_idle", D_RDATA, 32'h0);
    end

    initial begin
        total   = 0;
        bad     = 0;
        RSTn    = 1'b0;
        I_REQ   = 1'b1;
        I_ADDR  = 12'h005;
        D_REQ   = 1'b1;
        D_WE    = 1'b0;
        D_ADDR  = 12'h020;
        D_BE    = 4'h0;
        D_WDATA = 32'h0;
        adv();

        // 1: reset held with both requesting, then D wins the first cycle
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b0, "t1_rst");
            chk("t1_rst_i_rvalid", {31'h0, I_RVALID}, 32'h0);
            chk("t1_rst_d_rvalid", {31'h0, D_RVALID}, 32'h0);
            adv();
        end
        RSTn = 1'b1;
        push(1'b1, 32'h0000_0020);
        cyc(1'b0, 1'b1, "t1_first");
        adv();
        I_REQ = 1'b0;
        D_REQ = 1'b0;
        cyc(1'b0, 1'b0, "t1_idle");
        adv();

        // 2: partial write then read back of the same word
        D_REQ   = 1'b1;
        D_WE    = 1'b1;
        D_ADDR  = 12'h010;
        D_BE    = 4'b0011;
        D_WDATA = 32'hAABB_CCDD;
        cyc(1'b0, 1'b1, "t2_wr");
        chk("t2_wr_wen", {31'h0, M_WEN}, 32'h0);
        chk("t2_wr_be", {28'h0, M_BE}, 32'h3);
        chk("t2_wr_di", M_DI, 32'hAABB_CCDD);
        chk("t2_wr_addr", {20'h0, M_ADDR}, 32'h10);
        adv();
        D_WE = 1'b0;
        push(1'b1, 32'h0000_CCDD);
        cyc(1'b0, 1'b1, "t2_rd");
        chk("t2_rd_wen", {31'h0, M_WEN}, 32'h1);
        adv();
        D_REQ = 1'b0;
        cyc(1'b0, 1'b0, "t2_idle");
        chk("t2_idle_be", {28'h0, M_BE}, 32'h0);
        chk("t2_idle_addr", {20'h0, M_ADDR}, 32'h0);
        chk("t2_idle_di", M_DI, 32'h0);
        chk("t2_idle_wen", {31'h0, M_WEN}, 32'h1);
        adv();

        // 3: back-to-back instruction reads
        I_REQ  = 1'b1;
        I_ADDR = 12'h001;
        push(1'b0, 32'h1);
        cyc(1'b1, 1'b0, "t3_a");
        chk("t3_a_be", {28'h0, M_BE}, 32'hF);
        chk("t3_a_addr", {20'h0, M_ADDR}, 32'h1);
        chk("t3_a_wen", {31'h0, M_WEN}, 32'h1);
        adv();
        I_ADDR = 12'h002;
        push(1'b0, 32'h2);
        cyc(1'b1, 1'b0, "t3_b");
        adv();
        I_REQ = 1'b0;
        cyc(1'b0, 1'b0, "t3_idle");
        adv();
        cyc(1'b0, 1'b0, "t3_idle2");
        adv();

        I_REQ  = 1'b1;
        I_ADDR = 12'h005;
        D_REQ  = 1'b1;
        D_WE   = 1'b0;
        D_ADDR = 12'h007;
`ifndef ROUND_ROBIN_EN
        // 4: fixed priority with starvation guard -> D,D,D,D,I repeating
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) push(1'b0, 32'h5);
            else push(1'b1, 32'h7);
            cyc(k % 5 == 4, k % 5 != 4, "t4_conflict");
            adv();
        end
        // an idle I cycle restarts the starvation count
        for (int k = 0; k < 3; k++) begin
            push(1'b1, 32'h7);
            cyc(1'b0, 1'b1, "t4b_pre");
            adv();
        end
        I_REQ = 1'b0;
        push(1'b1, 32'h7);
        cyc(1'b0, 1'b1, "t4b_gap");
        adv();
        I_REQ = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) push(1'b0, 32'h5);
            else push(1'b1, 32'h7);
            cyc(k == 4, k != 4, "t4b_post");
            adv();
        end
`else
        // 5: round robin alternates starting with D (last grant was I)
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 1) push(1'b0, 32'h5);
            else push(1'b1, 32'h7);
            cyc(k % 2 == 1, k % 2 == 0, "t5_rr");
            adv();
        end
`endif
        I_REQ = 1'b0;
        D_REQ = 1'b0;
        cyc(1'b0, 1'b0, "t4_idle");
        adv();
        cyc(1'b0, 1'b0, "t4_idle2");
        adv();

        // 6: reset on the response cycle drops the D read response
        D_REQ  = 1'b1;
        D_ADDR = 12'h007;
        cyc(1'b0, 1'b1, "t6_rd");
        adv();
        RSTn  = 1'b0;
        D_REQ = 1'b0;
        cyc(1'b0, 1'b0, "t6_rst");
        chk("t6_rst_d_rvalid", {31'h0, D_RVALID}, 32'h0);
        chk("t6_rst_d_rdata", D_RDATA, 32'h0);
        adv();
        RSTn = 1'b1;
        cyc(1'b0, 1'b0, "t6_after");
        chk("t6_after_d_rvalid", {31'h0, D_RVALID}, 32'h0);
        adv();
        cyc(1'b0, 1'b0, "t6_after2");
        adv();

        chk("rsp_q_empty", rsp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
